// File: rtl/hack_memory_bus.sv
// Hack data-memory stage: RAM/screen/KBD decode, screen scanout over valid/ready, key-event intake.
// Optional key-event FIFO is enabled by defining HACK_KBD_FIFO_EN.
module hack_memory_bus #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  output logic        key_ready,
  output logic        vid_valid,
  input  logic        vid_ready,
  output logic [15:0] vid_data,
  output logic        vid_sof
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SP_W   = $clog2(SCREEN_WORDS);

  logic [15:0] ram_mem    [RAM_WORDS];
  logic [15:0] screen_mem [SCREEN_WORDS];

  logic            ram_sel;
  logic            scr_sel;
  logic            kbd_sel;
  logic [15:0]     kbd_value;
  logic [SP_W-1:0] sp_reg;
  logic [15:0]     vid_data_reg;
  logic            vid_valid_reg;
  logic            vid_sof_reg;
  logic            vid_load;

  assign ram_sel = (addressM[14] == 1'b0);
  assign scr_sel = (addressM[14:13] == 2'b10);
  assign kbd_sel = (addressM == 15'h6000);

  // Memories carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (writeM && ram_sel) ram_mem[addressM[RAM_AW-1:0]] <= outM;
    if (writeM && scr_sel) screen_mem[addressM[SP_W-1:0]] <= outM;
  end

  always_comb begin
    inM = '0;
    if (ram_sel)      inM = ram_mem[addressM[RAM_AW-1:0]];
    else if (scr_sel) inM = screen_mem[addressM[SP_W-1:0]];
    else if (kbd_sel) inM = kbd_value;
  end

  // Scanout: the read of screen_mem[sp] sees the pre-edge contents, so a same-edge CPU write lands next frame.
  assign vid_load = !vid_valid_reg || vid_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_reg        <= '0;
      vid_data_reg  <= '0;
      vid_valid_reg <= 1'b0;
      vid_sof_reg   <= 1'b0;
    end else if (vid_load) begin
      vid_data_reg  <= screen_mem[sp_reg];
      vid_sof_reg   <= (sp_reg == '0);
      vid_valid_reg <= 1'b1;
      sp_reg        <= (sp_reg == SP_W'(SCREEN_WORDS - 1)) ? '0 : sp_reg + SP_W'(1);
    end
  end

  assign vid_data  = vid_data_reg;
  assign vid_valid = vid_valid_reg;
  assign vid_sof   = vid_sof_reg;

`ifdef HACK_KBD_FIFO_EN
  localparam int KP_W = $clog2(KBD_DEPTH);
  localparam logic [KP_W:0] KBD_FULL_CNT = (KP_W + 1)'(KBD_DEPTH);

  logic [15:0]     kbd_fifo [KBD_DEPTH];
  logic [KP_W-1:0] rd_ptr_reg;
  logic [KP_W-1:0] wr_ptr_reg;
  logic [KP_W:0]   count_reg;
  logic [KP_W:0]   count_next;
  logic            kbd_push;
  logic            kbd_pop;

  assign key_ready = (count_reg != KBD_FULL_CNT);
  assign kbd_push  = key_valid && key_ready;
  // A CPU write to the KBD address acknowledges the head entry; popping an empty FIFO does nothing.
  assign kbd_pop   = writeM && kbd_sel && (count_reg != '0);
  assign kbd_value = (count_reg != '0) ? kbd_fifo[rd_ptr_reg] : 16'h0000;

  always_comb begin
    count_next = count_reg;
    case ({kbd_push, kbd_pop})
      2'b10:   count_next = count_reg + (KP_W + 1)'(1);
      2'b01:   count_next = count_reg - (KP_W + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (kbd_push) kbd_fifo[wr_ptr_reg] <= key_code;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (kbd_push) wr_ptr_reg <= wr_ptr_reg + KP_W'(1);
      if (kbd_pop)  rd_ptr_reg <= rd_ptr_reg + KP_W'(1);
      count_reg <= count_next;
    end
  end
`else
  logic [15:0] kbd_reg;

  assign key_ready = 1'b1;
  assign kbd_value = kbd_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          kbd_reg <= '0;
    else if (key_valid) kbd_reg <= key_code;
  end
`endif

endmodule
